// File: rtl/cmpl_seq.sv
// Digit-serial two's-complement engine: NEG / ABS / ONES / PASS, DIGIT bits per cycle, LSB first.
// Define CMPL_SAT_EN to saturate the most-negative overflow to the most-positive value.
module cmpl_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] MODE_NEG  = 2'b00;
  localparam logic [1:0] MODE_ABS  = 2'b01;
  localparam logic [1:0] MODE_ONES = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef CMPL_SAT_EN
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [CW-1:0]    cnt;
  logic             invert;
  logic             carry;
  logic             ovf_pend;

  logic             latch;
  logic             last;
  logic             inv_c;
  logic             cin_c;
  logic             ovf_c;
  logic [DIGIT-1:0] dsel;
  logic [DIGIT:0]   sum;

  // Next state, per-operation control decode and the slice adder
  always_comb begin
    state_n = state;
    latch   = 1'b0;
    last    = 1'b0;
    inv_c   = 1'b0;
    cin_c   = 1'b0;

    case (mode)
      MODE_NEG:  begin inv_c = 1'b1;             cin_c = 1'b1;             end
      MODE_ABS:  begin inv_c = data_in[WIDTH-1]; cin_c = data_in[WIDTH-1]; end
      MODE_ONES: begin inv_c = 1'b1;             cin_c = 1'b0;             end
      MODE_PASS: begin inv_c = 1'b0;             cin_c = 1'b0;             end
      default:   begin inv_c = 1'b0;             cin_c = 1'b0;             end
    endcase
    ovf_c = ((mode == MODE_NEG) || (mode == MODE_ABS)) && (data_in == MOST_NEG);

    dsel  = invert ? ~opnd[DIGIT-1:0] : opnd[DIGIT-1:0];
    sum   = {1'b0, dsel} + (DIGIT+1)'(carry);
    // New slice enters at the top; after N shifts the first slice sits at the LSB
    acc_n = WIDTH'({sum[DIGIT-1:0], acc} >> DIGIT);

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          latch   = 1'b1;
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt == CW'(N-1)) begin
          last    = 1'b1;
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      invert   <= 1'b0;
      carry    <= 1'b0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == S_RUN);
      done  <= (state_n == S_DONE);

      if (latch) begin
        opnd     <= data_in;
        invert   <= inv_c;
        carry    <= cin_c;
        ovf_pend <= ovf_c;
        cnt      <= '0;
      end else if (state == S_RUN) begin
        opnd  <= opnd >> DIGIT;
        carry <= sum[DIGIT];
        acc   <= acc_n;
        cnt   <= cnt + CW'(1);
      end

      if (last) begin
`ifdef CMPL_SAT_EN
        result <= ovf_pend ? MOST_POS : acc_n;
`else
        result <= acc_n;
`endif
        ovf    <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_cmpl_seq.sv
// Self-checking bench for cmpl_seq (WIDTH=8, DIGIT=2) against an arithmetic reference model.
module tb_cmpl_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIGIT = 2;
  localparam int unsigned N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] last_res;
  logic             last_ovf;

  always #5 clk = ~clk;

  cmpl_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .data_in(data_in),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  // Reference: {ovf, result} from the arithmetic meaning of each mode
  function automatic logic [8:0] model(input logic [1:0] m, input logic [7:0] x);
    logic [7:0] r;
    logic       o;
    o = ((m == 2'b00) || (m == 2'b01)) && (x == 8'h80);
    case (m)
      2'b00:   r = 8'(256 - int'(x));
      2'b01:   r = x[7] ? 8'(256 - int'(x)) : x;
      2'b10:   r = 8'(255 - int'(x));
      default: r = x;
    endcase
`ifdef CMPL_SAT_EN
    if (o) r = 8'h7F;
`endif
    return {o, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation (from IDLE or DONE) and check every cycle through DONE
  task automatic do_op(input logic [1:0] m, input logic [7:0] x, input bit noise);
    logic [8:0] exp;
    exp     = model(m, x);
    start   = 1'b1;
    mode    = m;
    data_in = x;
    tick();
    start   = 1'b0;
    mode    = 2'($urandom);
    data_in = 8'($urandom);
    for (int i = 0; i < int'(N); i++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || result !== last_res || ovf !== last_ovf) begin
        miscompares++;
        $display("FAIL run_cycle%0d m=%0d x=%h: busy=%b done=%b result=%h ovf=%b, required busy=1 done=0 result=%h ovf=%b",
                 i + 1, m, x, busy, done, result, ovf, last_res, last_ovf);
      end
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        mode    = 2'($urandom);
        data_in = 8'($urandom);
      end
      tick();
    end
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp[7:0] || ovf !== exp[8]) begin
      miscompares++;
      $display("FAIL done_cycle m=%0d x=%h: done=%b busy=%b result=%h ovf=%b, required done=1 busy=0 result=%h ovf=%b",
               m, x, done, busy, result, ovf, exp[7:0], exp[8]);
    end
    last_res = exp[7:0];
    last_ovf = exp[8];
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    data_in = 8'h00;
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b result=%h ovf=%b, required all zero", busy, done, result, ovf);
    end
    reset    = 1'b0;
    last_res = 8'h00;
    last_ovf = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0] ms [9];
    logic [7:0] xs [9];
    ms = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    xs = '{8'h03, 8'h80, 8'h80, 8'hF6, 8'h05, 8'h3C, 8'hA5, 8'h00, 8'h7F};
    for (int i = 0; i < 9; i++) begin
      do_op(ms[i], xs[i], 1'b0);
      tick();
    end
  endtask

  task automatic test_ignore_start_in_run();
    do_op(2'b00, 8'h01, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_op(2'b00, 8'h10, 1'b0);
    do_op(2'b10, 8'h5A, 1'b0);
    do_op(2'b01, 8'h80, 1'b0);
    tick();
  endtask

  task automatic test_mid_run_reset();
    do_op(2'b00, 8'h03, 1'b0);
    start   = 1'b1;
    mode    = 2'b00;
    data_in = 8'h03;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_run_reset: busy=%b done=%b result=%h ovf=%b, required all zero", busy, done, result, ovf);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    last_res = 8'h00;
    last_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
        miscompares++;
        $display("FAIL post_reset_quiet%0d: busy=%b done=%b result=%h, required busy=0 done=0 result=00", i, busy, done, result);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    do_op(2'b00, 8'h03, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 8'hFD || ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL hold%0d: busy=%b done=%b result=%h ovf=%b, required busy=0 done=0 result=fd ovf=0",
                 i, busy, done, result, ovf);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] x;
    int         gap;
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 7))
        0:       x = 8'h80;
        1:       x = 8'h7F;
        2:       x = 8'h00;
        3:       x = 8'hFF;
        default: x = 8'($urandom);
      endcase
      do_op(2'($urandom), x, 1'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start_in_run();
    test_back_to_back();
    test_mid_run_reset();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
